// File: rtl/decode_stage.sv
// decode_stage: registered decoder for the 9-bit accumulator ISA with
// valid/ready handshake, load-use interlock, flush and sticky halt.
module decode_stage #(
  parameter int NUM_REGS    = 12,
  parameter int INSTR_WIDTH = 9,
  parameter int REG_WIDTH   = 8,
  parameter int OP_WIDTH    = 4,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic [AW-1:0]          rs_addr,
  output logic [AW-1:0]          rt_addr,
  output logic [AW-1:0]          rd_addr,
  output logic [REG_WIDTH-1:0]   imm,
  output logic                   reg_write,
  output logic                   car_write,
  output logic                   sel_imm,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem2reg,
  output logic                   illegal,
  output logic                   halted
);

  localparam int EW = AW + 4;
  typedef logic [EW-1:0] ea_t;
  localparam ea_t NREG = ea_t'(NUM_REGS);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t state_q, state_d;

  logic [2:0] opc;
  ea_t fa, fb, fc, tr_s, tr_d;
  ea_t d_rs, d_rt, d_rd;
  logic [OP_WIDTH-1:0] d_op;
  logic [REG_WIDTH-1:0] d_imm;
  logic d_rw, d_cw, d_si, d_mr, d_mw, d_m2r;
  logic u_rs, u_rt, u_rd;
  logic d_bad, d_lw, d_halt, bad, ok;
  logic lu_valid;
  ea_t lu_rd;
  logic hit, stall, accept;

  assign opc  = instruction[INSTR_WIDTH-1 -: 3];
  assign fa   = ea_t'(instruction[5:4]);
  assign fb   = ea_t'(instruction[3:2]);
  assign fc   = ea_t'(instruction[1:0]);
  assign tr_s = ea_t'(instruction[2:0]);
  assign tr_d = ea_t'(instruction[5:3]);

  always_comb begin
    d_op   = '0;
    d_rs   = '0;
    d_rt   = '0;
    d_rd   = '0;
    d_imm  = '0;
    d_rw   = 1'b0;
    d_cw   = 1'b0;
    d_si   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_m2r  = 1'b0;
    u_rs   = 1'b0;
    u_rt   = 1'b0;
    u_rd   = 1'b0;
    d_bad  = 1'b0;
    d_lw   = 1'b0;
    d_halt = 1'b0;
    unique case (opc)
      3'b000: begin
        u_rs = 1'b1;
        u_rt = 1'b1;
        u_rd = 1'b1;
        d_rw = 1'b1;
        d_rs = fa + ea_t'(4);
        d_rt = fb;
        d_rd = ea_t'(11);
        unique case (instruction[1:0])
          2'b00: d_op = OP_WIDTH'(0);
          2'b01: begin
            d_op = OP_WIDTH'(1);
            d_rt = fb + ea_t'(8);
          end
          2'b10: d_op = OP_WIDTH'(2);
          default: d_op = OP_WIDTH'(5);
        endcase
      end
      3'b001: begin
        if (instruction[1]) begin
          d_bad = 1'b1;
        end else begin
          u_rs = 1'b1;
          d_rs = fa + ea_t'(4);
          d_op = OP_WIDTH'(6);
          if (instruction[0]) begin
            u_rt = 1'b1;
            d_rt = fb;
            d_mw = 1'b1;
          end else begin
            u_rd  = 1'b1;
            d_rd  = fb;
            d_rw  = 1'b1;
            d_mr  = 1'b1;
            d_m2r = 1'b1;
            d_lw  = 1'b1;
          end
        end
      end
      3'b010, 3'b110: begin
        u_rs = 1'b1;
        u_rt = 1'b1;
        u_rd = 1'b1;
        d_op = opc[2] ? OP_WIDTH'(5) : OP_WIDTH'(4);
        d_rs = fa + ea_t'(4);
        d_rt = fb;
        d_rd = fc + ea_t'(8);
        d_rw = 1'b1;
        d_cw = 1'b1;
      end
      3'b011: begin
        u_rs  = 1'b1;
        u_rd  = 1'b1;
        d_op  = OP_WIDTH'(4);
        d_rs  = fa + ea_t'(4);
        d_rd  = fa + ea_t'(4);
        d_imm = REG_WIDTH'(instruction[3:0]);
        d_si  = 1'b1;
        d_rw  = 1'b1;
        d_cw  = 1'b1;
      end
      3'b100: begin
        u_rs = 1'b1;
        u_rd = 1'b1;
        d_op = OP_WIDTH'(6);
        d_rs = tr_s + ea_t'(4);
        d_rd = tr_d;
        d_rw = 1'b1;
      end
      3'b101: begin
        u_rs = 1'b1;
        u_rt = 1'b1;
        d_op = OP_WIDTH'(7);
        d_rs = fa + ea_t'(4);
        d_rt = fb;
      end
      default: begin
        if (instruction[1:0] == 2'b11) begin
          d_halt = 1'b1;
        end else begin
          u_rs = 1'b1;
          u_rt = 1'b1;
          u_rd = 1'b1;
          d_op = OP_WIDTH'(8) + OP_WIDTH'(instruction[1:0]);
          d_rs = fa + ea_t'(4);
          d_rt = fb;
          d_rd = fa + ea_t'(4);
          d_rw = 1'b1;
          d_cw = 1'b1;
        end
      end
    endcase
  end

  assign bad = d_bad
             | (u_rs & (d_rs >= NREG))
             | (u_rt & (d_rt >= NREG))
             | (u_rd & (d_rd >= NREG));
  assign ok  = ~bad;

  // Only a register actually read by the incoming op can collide.
  assign hit = (u_rs & (d_rs == lu_rd))
             | (u_rt & (d_rt == lu_rd));
  assign stall = lu_valid & in_valid & hit
               & (state_q == RUN) & ~flush;

  assign in_ready = (state_q == RUN) & ~flush & ~stall
                  & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign halted = (state_q == HALTED);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (accept && d_halt) state_d = HALT_PEND;
      end
      HALT_PEND: begin
        if (flush) state_d = RUN;
        else if (out_valid && out_ready) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_op    <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      rd_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      car_write <= 1'b0;
      sel_imm   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem2reg   <= 1'b0;
      illegal   <= 1'b0;
      lu_valid  <= 1'b0;
      lu_rd     <= '0;
    end else if (state_q == HALTED) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      lu_valid  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_op    <= d_op;
      rs_addr   <= d_rs[AW-1:0];
      rt_addr   <= d_rt[AW-1:0];
      rd_addr   <= d_rd[AW-1:0];
      imm       <= d_imm;
      reg_write <= d_rw & ok;
      car_write <= d_cw & ok;
      sel_imm   <= d_si;
      mem_read  <= d_mr & ok;
      mem_write <= d_mw & ok;
      mem2reg   <= d_m2r & ok;
      illegal   <= bad;
      lu_valid  <= d_lw & ok;
      lu_rd     <= d_rd;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (stall)     lu_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: handshake, interlock,
// backpressure, address legality, halt and flush.
module tb_decode_stage;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [8:0] instruction;

  logic in_ready, out_valid;
  logic [3:0] alu_op;
  logic [AW-1:0] rs_addr, rt_addr, rd_addr;
  logic [7:0] imm;
  logic reg_write, car_write, sel_imm;
  logic mem_read, mem_write, mem2reg;
  logic illegal, halted;

  logic t_in_ready, t_out_valid;
  logic [3:0] t_alu_op;
  logic [AW-1:0] t_rs, t_rt, t_rd;
  logic [7:0] t_imm;
  logic t_rw, t_cw, t_si, t_mr, t_mw, t_m2r;
  logic t_illegal, t_halted;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .reg_write(reg_write), .car_write(car_write),
    .sel_imm(sel_imm), .mem_read(mem_read),
    .mem_write(mem_write), .mem2reg(mem2reg),
    .illegal(illegal), .halted(halted)
  );

  decode_stage #(.NUM_REGS(10)) dut10 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(t_in_ready),
    .instruction(instruction),
    .out_valid(t_out_valid), .out_ready(out_ready),
    .alu_op(t_alu_op), .rs_addr(t_rs),
    .rt_addr(t_rt), .rd_addr(t_rd), .imm(t_imm),
    .reg_write(t_rw), .car_write(t_cw),
    .sel_imm(t_si), .mem_read(t_mr),
    .mem_write(t_mw), .mem2reg(t_m2r),
    .illegal(t_illegal), .halted(t_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    instruction = '0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0d exp 0", out_valid); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rst_halted got %0d exp 0", halted); else passed++;
    total++; if (alu_op !== 4'd0) $display("FAIL rst_alu_op got %0d exp 0", alu_op); else passed++;
    total++; if (reg_write !== 1'b0) $display("FAIL rst_reg_write got %0d exp 0", reg_write); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0d exp 1", in_ready); else passed++;
  endtask

  task automatic test_add();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b010_01_10_11;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL add_in_ready got %0d exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %0d exp 1", out_valid); else passed++;
    total++; if (alu_op !== 4'd4) $display("FAIL add_alu_op got %0d exp 4", alu_op); else passed++;
    total++; if (rs_addr !== 4'd5) $display("FAIL add_rs got %0d exp 5", rs_addr); else passed++;
    total++; if (rt_addr !== 4'd2) $display("FAIL add_rt got %0d exp 2", rt_addr); else passed++;
    total++; if (rd_addr !== 4'd11) $display("FAIL add_rd got %0d exp 11", rd_addr); else passed++;
    total++; if ({reg_write, car_write} !== 2'b11) $display("FAIL add_strobes got %b exp 11", {reg_write, car_write}); else passed++;
    total++; if ({illegal, mem_read, mem_write} !== 3'b000) $display("FAIL add_misc got %b exp 000", {illegal, mem_read, mem_write}); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL add_drain got %0d exp 0", out_valid); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b001_00_11_00;
    tick();
    instruction = 9'b000_11_00_00;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL lw_valid got %0d exp 1", out_valid); else passed++;
    total++; if (rd_addr !== 4'd3) $display("FAIL lw_rd got %0d exp 3", rd_addr); else passed++;
    total++; if ({reg_write, mem_read, mem2reg, mem_write} !== 4'b1110) $display("FAIL lw_strobes got %b exp 1110", {reg_write, mem_read, mem2reg, mem_write}); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL nostall_in_ready got %0d exp 1", in_ready); else passed++;
    tick();
    instruction = 9'b001_00_00_00;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL and_valid got %0d exp 1", out_valid); else passed++;
    total++; if (alu_op !== 4'd0) $display("FAIL and_alu_op got %0d exp 0", alu_op); else passed++;
    total++; if (rs_addr !== 4'd7) $display("FAIL and_rs got %0d exp 7", rs_addr); else passed++;
    tick();
    instruction = 9'b000_11_00_00;
    #1;
    total++; if (rd_addr !== 4'd0) $display("FAIL lw0_rd got %0d exp 0", rd_addr); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %0d exp 0", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bubble_valid got %0d exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL post_stall_ready got %0d exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL dep_valid got %0d exp 1", out_valid); else passed++;
    total++; if (rt_addr !== 4'd0 || rd_addr !== 4'd11) $display("FAIL dep_fields got rt=%0d rd=%0d exp rt=0 rd=11", rt_addr, rd_addr); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b110_10_01_10;
    tick();
    out_ready = 1'b0;
    instruction = 9'b010_01_10_11;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0d exp 0", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0d exp 1", i, out_valid); else passed++;
      total++; if (alu_op !== 4'd5 || rs_addr !== 4'd6 || rt_addr !== 4'd1 || rd_addr !== 4'd10) $display("FAIL bp_hold[%0d] got op=%0d rs=%0d rt=%0d rd=%0d exp 5/6/1/10", i, alu_op, rs_addr, rt_addr, rd_addr); else passed++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0d exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_op !== 4'd4 || rd_addr !== 4'd11) $display("FAIL bp_next got v=%0d op=%0d rd=%0d exp 1/4/11", out_valid, alu_op, rd_addr); else passed++;
    tick();
  endtask

  task automatic test_tr_illegal();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b100_111_111;
    tick();
    instruction = 9'b001_00_00_10;
    #1;
    total++; if (rs_addr !== 4'd11 || rd_addr !== 4'd7) $display("FAIL tr_addr got rs=%0d rd=%0d exp 11/7", rs_addr, rd_addr); else passed++;
    total++; if (illegal !== 1'b0 || reg_write !== 1'b1) $display("FAIL tr_legal got ill=%0d rw=%0d exp 0/1", illegal, reg_write); else passed++;
    total++; if (alu_op !== 4'd6) $display("FAIL tr_alu_op got %0d exp 6", alu_op); else passed++;
    total++; if (t_out_valid !== 1'b1 || t_illegal !== 1'b1) $display("FAIL tr10_illegal got v=%0d ill=%0d exp 1/1", t_out_valid, t_illegal); else passed++;
    total++; if (t_rw !== 1'b0) $display("FAIL tr10_reg_write got %0d exp 0", t_rw); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1) $display("FAIL ill_flag got v=%0d ill=%0d exp 1/1", out_valid, illegal); else passed++;
    total++; if ({reg_write, car_write, mem_read, mem_write, mem2reg} !== 5'b0) $display("FAIL ill_strobes got %b exp 00000", {reg_write, car_write, mem_read, mem_write, mem2reg}); else passed++;
    tick();
  endtask

  task automatic test_addi();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b011_10_1101;
    tick();
    in_valid = 1'b0;
    total++; if (imm !== 8'd13 || sel_imm !== 1'b1) $display("FAIL addi_imm got imm=%0d sel=%0d exp 13/1", imm, sel_imm); else passed++;
    total++; if (rs_addr !== 4'd6 || rd_addr !== 4'd6) $display("FAIL addi_addr got rs=%0d rd=%0d exp 6/6", rs_addr, rd_addr); else passed++;
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b111_00_00_11;
    tick();
    instruction = 9'b010_01_10_11;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL halt_pend_ready got %0d exp 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b1 || halted !== 1'b0) $display("FAIL halt_bundle got v=%0d h=%0d exp 1/0", out_valid, halted); else passed++;
    total++; if (alu_op !== 4'd0 || reg_write !== 1'b0) $display("FAIL halt_fields got op=%0d rw=%0d exp 0/0", alu_op, reg_write); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL halted[%0d] got h=%0d v=%0d r=%0d exp 1/0/0", i, halted, out_valid, in_ready); else passed++;
      flush = (i == 1);
      tick();
    end
    flush = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || out_valid !== 1'b0) $display("FAIL halt_reset got h=%0d v=%0d exp 0/0", halted, out_valid); else passed++;
    total++; if ({alu_op, rs_addr, rt_addr, rd_addr} !== 16'h0) $display("FAIL halt_reset_fields got %h exp 0000", {alu_op, rs_addr, rt_addr, rd_addr}); else passed++;
  endtask

  task automatic test_flush_halt();
    do_reset();
    in_valid = 1'b1;
    instruction = 9'b111_00_00_11;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    instruction = 9'b010_01_10_11;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0d exp 0", in_ready); else passed++;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || halted !== 1'b0) $display("FAIL flush_out got v=%0d h=%0d exp 0/0", out_valid, halted); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_run_ready got %0d exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_op !== 4'd4) $display("FAIL flush_next got v=%0d op=%0d exp 1/4", out_valid, alu_op); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_backpressure();
    test_tr_illegal();
    test_addi();
    test_halt();
    test_flush_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
